alu_multicycle: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds logical shifts and an iterative multiplier; all results are registered.
- Uses a Start/Busy/Done handshake so the multicycle control unit can stall while a multiply completes.
- Sits in the EX stage between the register-file read buses and the writeback/memory-address path.

---
 rtl/alu_multicycle.sv | 193 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU with logical shifts and a radix-2 shift-add multiplier (Start/Busy/Done).
// Optional N/C/V flag outputs are built when ALU_FLAGS_EN is defined.
module alu_multicycle #(
    parameter int WIDTH    = 64,
    parameter int MOVSHIFT = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_bus_a,
    input  logic [WIDTH-1:0] i_bus_b,
    input  logic [3:0]       i_alu_ctrl,
    output logic [WIDTH-1:0] o_bus_w,
    output logic             o_zero,
    output logic             o_busy,
`ifdef ALU_FLAGS_EN
    output logic             o_negative,
    output logic             o_carry,
    output logic             o_overflow,
`endif
    output logic             o_done
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_PASSB  = 4'b0111;
    localparam logic [3:0] OP_PASSBM = 4'b1000;
    localparam logic [3:0] OP_LSL    = 4'b1001;
    localparam logic [3:0] OP_LSR    = 4'b1010;
    localparam logic [3:0] OP_MUL    = 4'b1011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_bus_w;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic [WIDTH-1:0] r_mul_acc;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_mul_acc_next;

    assign w_shamt        = i_bus_b[SHW-1:0];
    assign w_mul_acc_next = r_mul_acc + (r_mul_b[0] ? r_mul_a : {WIDTH{1'b0}});

    // Single-cycle result, evaluated from the live inputs at the accept edge
    always_comb begin
        w_result = {WIDTH{1'b0}};
        case (i_alu_ctrl)
            OP_AND:    w_result = i_bus_a & i_bus_b;
            OP_OR:     w_result = i_bus_a | i_bus_b;
            OP_ADD:    w_result = i_bus_a + i_bus_b;
            OP_SUB:    w_result = i_bus_a - i_bus_b;
            OP_PASSB:  w_result = i_bus_b << MOVSHIFT;
            OP_PASSBM: w_result = i_bus_b;
            OP_LSL:    w_result = i_bus_a << w_shamt;
            OP_LSR:    w_result = i_bus_a >> w_shamt;
            default:   w_result = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_add_ext;
    logic [WIDTH:0] w_sub_ext;
    logic           w_carry;
    logic           w_ovf;
    logic           r_negative;
    logic           r_carry;
    logic           r_overflow;

    // SUB carry is the carry-out of A + ~B + 1, i.e. "no borrow"
    assign w_add_ext = {1'b0, i_bus_a} + {1'b0, i_bus_b};
    assign w_sub_ext = {1'b0, i_bus_a} + {1'b0, ~i_bus_b} + {{WIDTH{1'b0}}, 1'b1};

    // Carry/overflow for the arithmetic ops; cleared for everything else
    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_alu_ctrl)
            OP_ADD: begin
                w_carry = w_add_ext[WIDTH];
                w_ovf   = (i_bus_a[WIDTH-1] == i_bus_b[WIDTH-1]) &&
                          (w_add_ext[WIDTH-1] != i_bus_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_carry = w_sub_ext[WIDTH];
                w_ovf   = (i_bus_a[WIDTH-1] != i_bus_b[WIDTH-1]) &&
                          (w_sub_ext[WIDTH-1] != i_bus_a[WIDTH-1]);
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    assign o_negative = r_negative;
    assign o_carry    = r_carry;
    assign o_overflow = r_overflow;
`endif

    // Control FSM, multiplier datapath and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_bus_w   <= {WIDTH{1'b0}};
            r_zero    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= {SHW{1'b0}};
            r_mul_a   <= {WIDTH{1'b0}};
            r_mul_b   <= {WIDTH{1'b0}};
            r_mul_acc <= {WIDTH{1'b0}};
`ifdef ALU_FLAGS_EN
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_alu_ctrl == OP_MUL) begin
                            r_state   <= S_MUL;
                            r_busy    <= 1'b1;
                            r_cnt     <= {SHW{1'b0}};
                            r_mul_a   <= i_bus_a;
                            r_mul_b   <= i_bus_b;
                            r_mul_acc <= {WIDTH{1'b0}};
                        end else begin
                            r_bus_w <= w_result;
                            r_zero  <= is_zero(w_result);
                            r_done  <= 1'b1;
`ifdef ALU_FLAGS_EN
                            r_negative <= w_result[WIDTH-1];
                            r_carry    <= w_carry;
                            r_overflow <= w_ovf;
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_mul_acc <= w_mul_acc_next;
                    r_mul_a   <= r_mul_a << 1;
                    r_mul_b   <= r_mul_b >> 1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= {SHW{1'b0}};
                        r_bus_w <= w_mul_acc_next;
                        r_zero  <= is_zero(w_mul_acc_next);
`ifdef ALU_FLAGS_EN
                        r_negative <= w_mul_acc_next[WIDTH-1];
                        r_carry    <= 1'b0;
                        r_overflow <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_bus_w = r_bus_w;
    assign o_zero  = r_zero;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors push expectations, a monitor checks each Done.
module tb_alu_multicycle;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;
    logic [3:0]   ctrl;
    logic [W-1:0] bus_w;
    logic         zero;
    logic         busy;
    logic         done;
`ifdef ALU_FLAGS_EN
    logic         neg;
    logic         carry;
    logic         ovf;
`endif

    typedef struct {
        string        name;
        logic [W-1:0] w;
        logic         z;
        logic [2:0]   nzv;   // {negative, carry, overflow}
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_multicycle #(.WIDTH(W), .MOVSHIFT(16)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_bus_a    (bus_a),
        .i_bus_b    (bus_b),
        .i_alu_ctrl (ctrl),
        .o_bus_w    (bus_w),
        .o_zero     (zero),
        .o_busy     (busy),
`ifdef ALU_FLAGS_EN
        .o_negative (neg),
        .o_carry    (carry),
        .o_overflow (ovf),
`endif
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request for one edge; expectation is queued only for ops that must complete
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input string name, input logic [W-1:0] ew,
                         input logic [2:0] enzv);
        exp_t e;
        if (push) begin
            e.name = name;
            e.w    = ew;
            e.z    = (ew == {W{1'b0}});
            e.nzv  = enzv;
            exp_q.push_back(e);
        end
        start = 1'b1;
        ctrl  = op;
        bus_a = a;
        bus_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor: every Done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with bus_w=%h, expected no completion", bus_w);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_busw"}, bus_w, e.w);
                chk({e.name, "_zero"}, {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, e.z});
                chk({e.name, "_busy_in_done"}, {{(W-1){1'b0}}, busy}, {W{1'b0}});
`ifdef ALU_FLAGS_EN
                chk({e.name, "_flags"}, {{(W-3){1'b0}}, neg, carry, ovf}, {{(W-3){1'b0}}, e.nzv});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        ctrl  = 4'b0000;
        bus_a = {W{1'b0}};
        bus_b = {W{1'b0}};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busw", bus_w, {W{1'b0}});
        chk("rst_zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, 1'b1});
        chk("rst_busy", {{(W-1){1'b0}}, busy}, {W{1'b0}});
        chk("rst_done", {{(W-1){1'b0}}, done}, {W{1'b0}});

        // Back-to-back single-cycle ops: one Done per cycle
        issue(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, "add_ovf",   64'h8000_0000_0000_0000, 3'b101);
        issue(4'b0110, 64'h5, 64'h5,                 1'b1, "sub_eq",    64'h0,                   3'b010);
        issue(4'b0111, 64'h0, 64'hABCD,              1'b1, "passb",     64'hABCD_0000,           3'b000);
        issue(4'b1010, 64'hF0, 64'h44,               1'b1, "lsr",       64'h0F,                  3'b000);
        issue(4'b0001, 64'hF0, 64'h0F,               1'b1, "or",        64'hFF,                  3'b000);
        issue(4'b1001, 64'h1, 64'h3F,                1'b1, "lsl63",     64'h8000_0000_0000_0000, 3'b100);
        issue(4'b1000, 64'h9, 64'h1234,              1'b1, "passbm",    64'h1234,                3'b000);
        issue(4'b0011, 64'h5, 64'h5,                 1'b1, "undef_op",  64'h0,                   3'b000);
        issue(4'b0110, 64'h3, 64'h5,                 1'b1, "sub_neg",   64'hFFFF_FFFF_FFFF_FFFE, 3'b100);
        @(posedge clk);
        #1;

        // MUL with an ignored mid-operation Start and operand changes
        issue(4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 1'b1, "mul",    64'hFFFF_FFFF_FFFF_FFFD, 3'b100);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 9) begin
                start = 1'b1;
                ctrl  = 4'b0010;
                bus_a = 64'h1;
                bus_b = 64'h1;
            end else if (n == 10) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("mul_busy_cycles", 64'(n), 64'd64);
        chk("mul_done_at_64", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, 1'b1});
        // Start in the MUL Done cycle is accepted
        issue(4'b0010, 64'h2, 64'h3, 1'b1, "add_in_done", 64'h5, 3'b000);
        @(posedge clk);
        #1;

        // Reset at cycle 10 of a MUL aborts it without a Done
        issue(4'b1011, 64'h5, 64'h7, 1'b0, "mul_abort", 64'h0, 3'b000);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", {{(W-1){1'b0}}, busy}, {W{1'b0}});
        chk("abort_busw", bus_w, {W{1'b0}});
        chk("abort_zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, 1'b1});
        chk("abort_done", {{(W-1){1'b0}}, done}, {W{1'b0}});
        repeat (70) @(posedge clk);
        #1;
        issue(4'b0000, 64'hF0F0, 64'hFF00, 1'b1, "and", 64'hF000, 3'b000);
        @(posedge clk);
        #1;

        // Reset together with Start: nothing accepted
        reset = 1'b1;
        start = 1'b1;
        ctrl  = 4'b0010;
        bus_a = 64'h1;
        bus_b = 64'h1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_done", {{(W-1){1'b0}}, done}, {W{1'b0}});
        chk("rst_start_busw", bus_w, {W{1'b0}});
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
